csr_unit: RTL and testbench
===========================

# csr_unit

Parametrised machine-mode CSR unit, the successor to the single-cycle CSR file. It adds mstatus interrupt-enable stacking, mret handling, an IRQ_NUM-wide interrupt pending/enable path with interrupt request generation, and optional cycle/instret counters. It sits beside the decoder in the core's execute stage and drives trap and return target addresses to the PC mux.

## Interface
- IRQ_NUM, default 16: number of platform interrupt lines, 1..16; they map to mip/mie bits [16+IRQ_NUM-1:16].
- CNT_W, default 64: counter width, 32..64.
- MTVEC_RST, default 32'h0000_0000: reset value of mtvec.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- opcode_i  in  3  CSR op, csr_pkg encoding: CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI.
- addr_i  in  12  CSR address.
- rs1_data_i / imm_data_i  in  32  write operand sources.
- write_enable_i  in  1  commit the CSR op this cycle.
- trap_i  in  1  take a trap this cycle; pc_i is the faulting or interrupted PC.
- mret_i  in  1  execute mret this cycle.
- pc_i  in  32  PC of the current instruction.
- mcause_i  in  32  exception cause, used when trap_i is asserted and irq_o is low.
- instret_i  in  1  one instruction retired this cycle.
- irq_i  in  IRQ_NUM  level-sensitive interrupt lines.
- read_data_o  out  32  combinational read of addr_i; 0 for unmapped addresses.
- illegal_o  out  1  combinational; high when write_enable_i is set and addr_i is unmapped.
- irq_o  out  1  interrupt request to the core.
- mepc_o / mtvec_o  out  32  trap return and trap vector.

## Operation
- Mapped registers:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; all other bits read 0.
  - mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
  - mip 0x344: read-only; writes are ignored and do not raise illegal_o.
- mie writable bits: only bits [16+IRQ_NUM-1:16]; all other bits read 0.
- Write data is formed from opcode_i:
  - RW: operand.
  - RS: old | operand.
  - RC: old & ~operand.
  - Operand is rs1_data_i for RW/RS/RC and imm_data_i for the I variants.
  - Undefined opcode: treated as RW.
- mip[16+k] is a one-cycle registered copy of irq_i[k].
- pend = mip & mie. irq_o = mstatus.MIE & |pend.
- Trap (trap_i):
  - mepc <= pc_i.
  - mcause <= irq_o ? {1'b1, 31'(16+idx)} : mcause_i, where idx is the lowest set bit of pend.
  - MPIE <= MIE; MIE <= 0.
- mret (mret_i): MIE <= MPIE; MPIE <= 1.
- Priority in one cycle is trap_i > mret_i > CSR write. A lower-priority event's update to a register also touched by a higher-priority event is discarded. Updates to untouched registers still occur.
- mepc bits [1:0] always read 0 (write-masked).
- mtvec is direct mode only; bits [1:0] read 0.

## Timing
- All reads are combinational from register state. All writes take effect at the next posedge.
- Reset (asynchronous, on rst_ni low):
  - mstatus, mie, mip, mscratch, mepc, mcause, counters = 0; mtvec = MTVEC_RST.
  - Resulting outputs: irq_o = 0, mepc_o = 0, read_data_o = 0 for all addresses except mtvec.
- Reset asserted mid-operation overrides any pending trap, mret or write in that cycle.
- Interrupt latency: irq_i rising at edge N gives mip set after edge N+1. irq_o is high in that same cycle if MIE and mie are set.
- irq_o drops in the cycle after a trap, because MIE is cleared.

## Configuration
- CSR_COUNTERS_EN defined:
  - Map mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, all CNT_W wide.
  - mcycle increments every cycle; minstret increments when instret_i is high. Both wrap to 0.
  - A CSR write to a half replaces that half for the cycle; the increment is suppressed in that cycle.
  - For CNT_W < 64, upper bits read 0. For CNT_W = 32, the h registers read 0 and writes to them are ignored.
- CSR_COUNTERS_EN undefined:
  - Counters are absent, instret_i is ignored, and the four addresses are unmapped (read 0, illegal_o on write).

## Test plan
- Reset, then read every address -> 0, except mtvec = MTVEC_RST; irq_o = 0.
- Write mscratch with RW 0xF0F0_F0F0, then RS 0x0F, then RC 0xF0 -> reads 0xF0F0_F0F0, 0xF0F0_F0FF, 0xF0F0_F00F.
- Set mie[17] and MIE, then pulse irq_i[1] -> irq_o high one cycle later. Pulse trap_i with pc_i = 0x100 -> mepc = 0x100, mcause = 0x8000_0011, MIE = 0, MPIE = 1, irq_o low.
- Pulse mret_i after the trap -> MIE = 1, MPIE = 1.
- Assert trap_i (mcause_i = 2), mret_i and a write to mepc in one cycle -> mepc = pc_i, mcause = 2.
- With CSR_COUNTERS_EN and CNT_W = 64: write mcycle = 0xFFFF_FFFF -> next cycle mcycle = 0, mcycleh = 1. Write 0x1234 to 0x300 -> mstatus reads 0 (bits 3 and 7 of 0x1234 are 0).

Source files
------------

// File: rtl/csr_unit_if.sv
// CSR access bus for csr_unit, plus the csr_pkg definitions it shares with
// the decoder (opcode encoding and register addresses).
//
// Handshake: there is no valid/ready pair. The master holds opcode_i,
// addr_i, rs1_data_i and imm_data_i stable and raises write_enable_i for
// exactly the cycle in which the operation commits. read_data_o and
// illegal_o are combinational from addr_i/write_enable_i and register state,
// so they are valid in the same cycle. The write lands at the next posedge.

package csr_pkg;
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
endpackage

interface csr_unit_if;
  logic [2:0]  opcode_i;
  logic [11:0] addr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] imm_data_i;
  logic        write_enable_i;
  logic [31:0] read_data_o;
  logic        illegal_o;

  modport master (
    output opcode_i, addr_i, rs1_data_i, imm_data_i, write_enable_i,
    input  read_data_o, illegal_o
  );

  modport slave (
    input  opcode_i, addr_i, rs1_data_i, imm_data_i, write_enable_i,
    output read_data_o, illegal_o
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with mstatus MIE/MPIE stacking, mret,
// IRQ_NUM platform interrupt lines on mip/mie[16+IRQ_NUM-1:16] and irq_o
// generation. Optional cycle/instret counters are built when the macro
// CSR_COUNTERS_EN is defined; otherwise their addresses are unmapped.
// Event priority within one cycle: trap_i > mret_i > CSR write; only the
// registers a higher-priority event touches are protected.

module csr_unit
  import csr_pkg::*;
#(
  parameter int          IRQ_NUM   = 16,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  csr_unit_if.slave          bus,
  input  logic               trap_i,
  input  logic               mret_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        mcause_i,
  input  logic               instret_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  output logic               irq_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        mtvec_o
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic               mst_mie_q, mst_mpie_q;
  logic [IRQ_NUM-1:0] mie_q, mip_q;
  logic [31:0]        mtvec_q, mscratch_q, mepc_q, mcause_q;

  logic [31:0]        mstatus_rd, mie_rd, mip_rd;
  logic [IRQ_NUM-1:0] pend;
  logic [4:0]         irq_idx;
  logic [31:0]        irq_cause;
  logic [31:0]        rd_data;
  logic               mapped;
  logic [31:0]        operand, wdata;
  logic               wr_en;
  logic               we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause;

  assign mstatus_rd = {24'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};

  // Place the IRQ_NUM-wide mie/mip fields at bit 16 for reads.
  always_comb begin
    mie_rd = '0;
    mip_rd = '0;
    mie_rd[16 +: IRQ_NUM] = mie_q;
    mip_rd[16 +: IRQ_NUM] = mip_q;
  end

  assign pend  = mip_q & mie_q;
  assign irq_o = mst_mie_q & (|pend);

  // Lowest pending, enabled line selects the interrupt cause.
  always_comb begin
    irq_idx = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (pend[k]) irq_idx = 5'(k);
    end
  end
  assign irq_cause = 32'h8000_0010 + {27'd0, irq_idx};

`ifdef CSR_COUNTERS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] mcycle_q, minstret_q;
  logic [63:0]      mcycle_ext, minstret_ext;
  logic [63:0]      mcycle_nxt, minstret_nxt;
  logic             we_mcycle, we_mcycleh, we_minstret, we_minstreth;
  logic             hold_mcycle, hold_minstret;

  assign mcycle_ext   = 64'(mcycle_q);
  assign minstret_ext = 64'(minstret_q);
`else
  // Counters are absent: instret_i and CNT_W have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = instret_i ^ (CNT_W > 64);
`endif

  // Combinational read mux; also tells whether addr_i is a mapped CSR.
  always_comb begin
    rd_data = '0;
    mapped  = 1'b1;
    case (bus.addr_i)
      ADDR_MSTATUS:   rd_data = mstatus_rd;
      ADDR_MIE:       rd_data = mie_rd;
      ADDR_MTVEC:     rd_data = mtvec_q;
      ADDR_MSCRATCH:  rd_data = mscratch_q;
      ADDR_MEPC:      rd_data = mepc_q;
      ADDR_MCAUSE:    rd_data = mcause_q;
      ADDR_MIP:       rd_data = mip_rd;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    rd_data = mcycle_ext[31:0];
      ADDR_MCYCLEH:   rd_data = mcycle_ext[63:32];
      ADDR_MINSTRET:  rd_data = minstret_ext[31:0];
      ADDR_MINSTRETH: rd_data = minstret_ext[63:32];
`endif
      default:        mapped  = 1'b0;
    endcase
  end

  assign bus.read_data_o = rd_data;
  assign bus.illegal_o   = bus.write_enable_i & ~mapped;

  // Form the write value from the opcode; unknown opcodes behave as CSR_RW.
  always_comb begin
    operand = bus.rs1_data_i;
    wdata   = bus.rs1_data_i;
    case (bus.opcode_i)
      CSR_RW:  begin operand = bus.rs1_data_i; wdata = operand;            end
      CSR_RS:  begin operand = bus.rs1_data_i; wdata = rd_data | operand;  end
      CSR_RC:  begin operand = bus.rs1_data_i; wdata = rd_data & ~operand; end
      CSR_RWI: begin operand = bus.imm_data_i; wdata = operand;            end
      CSR_RSI: begin operand = bus.imm_data_i; wdata = rd_data | operand;  end
      CSR_RCI: begin operand = bus.imm_data_i; wdata = rd_data & ~operand; end
      default: begin operand = bus.rs1_data_i; wdata = operand;            end
    endcase
  end

  assign wr_en       = bus.write_enable_i & mapped;
  assign we_mstatus  = wr_en && (bus.addr_i == ADDR_MSTATUS);
  assign we_mie      = wr_en && (bus.addr_i == ADDR_MIE);
  assign we_mtvec    = wr_en && (bus.addr_i == ADDR_MTVEC);
  assign we_mscratch = wr_en && (bus.addr_i == ADDR_MSCRATCH);
  assign we_mepc     = wr_en && (bus.addr_i == ADDR_MEPC);
  assign we_mcause   = wr_en && (bus.addr_i == ADDR_MCAUSE);

  // mstatus: trap stacks MIE into MPIE, mret unstacks, else a CSR write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
    end else if (trap_i) begin
      mst_mpie_q <= mst_mie_q;
      mst_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mst_mie_q  <= mst_mpie_q;
      mst_mpie_q <= 1'b1;
    end else if (we_mstatus) begin
      mst_mie_q  <= wdata[3];
      mst_mpie_q <= wdata[7];
    end
  end

  // mepc/mcause: trap capture wins over a CSR write in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_i) begin
      mepc_q   <= pc_i & ALIGN_MASK;
      mcause_q <= irq_o ? irq_cause : mcause_i;
    end else begin
      if (we_mepc)   mepc_q   <= wdata & ALIGN_MASK;
      if (we_mcause) mcause_q <= wdata;
    end
  end

  // Registers no trap or mret touches: plain CSR writes, plus mip sampling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RST & ALIGN_MASK;
      mscratch_q <= '0;
    end else begin
      mip_q <= irq_i;
      if (we_mie)      mie_q      <= wdata[16 +: IRQ_NUM];
      if (we_mtvec)    mtvec_q    <= wdata & ALIGN_MASK;
      if (we_mscratch) mscratch_q <= wdata;
    end
  end

`ifdef CSR_COUNTERS_EN
  assign we_mcycle    = wr_en && (bus.addr_i == ADDR_MCYCLE);
  assign we_mcycleh   = wr_en && (bus.addr_i == ADDR_MCYCLEH);
  assign we_minstret  = wr_en && (bus.addr_i == ADDR_MINSTRET);
  assign we_minstreth = wr_en && (bus.addr_i == ADDR_MINSTRETH);

  // A write to the high half only counts when the counter has one.
  assign hold_mcycle   = we_mcycle   | (we_mcycleh   && (CNT_W > 32));
  assign hold_minstret = we_minstret | (we_minstreth && (CNT_W > 32));

  // Splice a written half into the 64-bit view of each counter.
  always_comb begin
    mcycle_nxt   = mcycle_ext;
    minstret_nxt = minstret_ext;
    if (we_mcycle)    mcycle_nxt[31:0]    = wdata;
    if (we_mcycleh)   mcycle_nxt[63:32]   = wdata;
    if (we_minstret)  minstret_nxt[31:0]  = wdata;
    if (we_minstreth) minstret_nxt[63:32] = wdata;
  end

  // Counters: a write replaces a half and suppresses that cycle's increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (hold_mcycle) mcycle_q <= mcycle_nxt[CNT_W-1:0];
      else             mcycle_q <= mcycle_q + CNT_ONE;
      if (hold_minstret)  minstret_q <= minstret_nxt[CNT_W-1:0];
      else if (instret_i) minstret_q <= minstret_q + CNT_ONE;
    end
  end
`endif

  assign mepc_o  = mepc_q;
  assign mtvec_o = mtvec_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit: reset values, read-modify-write ops,
// interrupt/trap/mret flow, same-cycle priority, alignment masking,
// illegal-address flagging, async reset mid-operation and (when built with
// CSR_COUNTERS_EN) counter write/wrap behaviour.

module tb_csr_unit;
  import csr_pkg::*;

  localparam int          IRQ_NUM   = 16;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

  logic               clk_i;
  logic               rst_ni;
  logic               trap_i, mret_i, instret_i;
  logic [31:0]        pc_i, mcause_i;
  logic [IRQ_NUM-1:0] irq_i;
  logic               irq_o;
  logic [31:0]        mepc_o, mtvec_o;

  csr_unit_if bus ();

  csr_unit #(
    .IRQ_NUM   (IRQ_NUM),
    .CNT_W     (64),
    .MTVEC_RST (MTVEC_RST)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .trap_i    (trap_i),
    .mret_i    (mret_i),
    .pc_i      (pc_i),
    .mcause_i  (mcause_i),
    .instret_i (instret_i),
    .irq_i     (irq_i),
    .irq_o     (irq_o),
    .mepc_o    (mepc_o),
    .mtvec_o   (mtvec_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_op(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [31:0] imm);
    bus.opcode_i       = op;
    bus.addr_i         = addr;
    bus.rs1_data_i     = rs1;
    bus.imm_data_i     = imm;
    bus.write_enable_i = 1'b1;
    cycle();
    bus.write_enable_i = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] addr, output logic [31:0] data);
    bus.addr_i = addr;
    #1;
    data = bus.read_data_o;
  endtask

  task automatic expect_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    csr_rd(addr, d);
    check(tag, d, exp);
  endtask

  logic [11:0] rst_addrs[8];
  logic [31:0] d, lo_before;

  // ---------------- stimulus ----------------
  initial begin
    rst_ni             = 1'b0;
    trap_i             = 1'b0;
    mret_i             = 1'b0;
    instret_i          = 1'b0;
    pc_i               = '0;
    mcause_i           = '0;
    irq_i              = '0;
    bus.opcode_i       = CSR_RW;
    bus.addr_i         = '0;
    bus.rs1_data_i     = '0;
    bus.imm_data_i     = '0;
    bus.write_enable_i = 1'b0;

    cycle();
    check("rst_irq_o", {31'd0, irq_o}, 32'd0);
    check("rst_mepc_o", mepc_o, 32'd0);
    cycle();
    rst_ni = 1'b1;
    cycle();

    // Reset values of every base address, plus one unmapped address.
    rst_addrs = '{ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
                  ADDR_MEPC, ADDR_MCAUSE, ADDR_MIP, 12'h7C0};
    foreach (rst_addrs[i]) exp_q.push_back(rst_addrs[i] == ADDR_MTVEC ? MTVEC_RST : 32'd0);
    foreach (rst_addrs[i]) begin
      csr_rd(rst_addrs[i], d);
      check($sformatf("rst_rd_%03h", rst_addrs[i]), d, exp_q.pop_front());
    end
    check("rst_mtvec_o", mtvec_o, MTVEC_RST);

    // Read-modify-write on mscratch.
    csr_op(CSR_RW, ADDR_MSCRATCH, 32'hF0F0_F0F0, 32'h0);
    expect_rd("mscratch_rw", ADDR_MSCRATCH, 32'hF0F0_F0F0);
    csr_op(CSR_RS, ADDR_MSCRATCH, 32'h0000_000F, 32'h0);
    expect_rd("mscratch_rs", ADDR_MSCRATCH, 32'hF0F0_F0FF);
    csr_op(CSR_RCI, ADDR_MSCRATCH, 32'hFFFF_FFFF, 32'h0000_00F0);
    expect_rd("mscratch_rci", ADDR_MSCRATCH, 32'hF0F0_F00F);
    csr_op(3'b000, ADDR_MSCRATCH, 32'h0000_1111, 32'h0000_2222);
    expect_rd("mscratch_undef_op", ADDR_MSCRATCH, 32'h0000_1111);

    // mie writable mask, then enable lines 1 and 3, then global MIE.
    csr_op(CSR_RW, ADDR_MIE, 32'hFFFF_FFFF, 32'h0);
    expect_rd("mie_mask", ADDR_MIE, 32'hFFFF_0000);
    csr_op(CSR_RW, ADDR_MIE, 32'h000A_0000, 32'h0);
    expect_rd("mie_set", ADDR_MIE, 32'h000A_0000);
    csr_op(CSR_RSI, ADDR_MSTATUS, 32'h0, 32'h0000_0008);
    expect_rd("mstatus_mie_set", ADDR_MSTATUS, 32'h0000_0008);

    // Interrupt: lines 1 and 3 rise; mip follows one edge later.
    irq_i = 16'h000A;
    #1;
    check("irq_o_before_edge", {31'd0, irq_o}, 32'd0);
    cycle();
    check("irq_o_after_edge", {31'd0, irq_o}, 32'd1);
    expect_rd("mip_set", ADDR_MIP, 32'h000A_0000);

    // Trap while the interrupt is pending: lowest line (1) wins the cause.
    trap_i   = 1'b1;
    pc_i     = 32'h0000_0100;
    mcause_i = 32'h0000_0005;
    cycle();
    trap_i = 1'b0;
    check("trap_mepc_o", mepc_o, 32'h0000_0100);
    expect_rd("trap_mcause", ADDR_MCAUSE, 32'h8000_0011);
    expect_rd("trap_mstatus", ADDR_MSTATUS, 32'h0000_0080);
    check("trap_irq_o_low", {31'd0, irq_o}, 32'd0);

    // mret restores MIE; the still-pending line raises irq_o again.
    mret_i = 1'b1;
    cycle();
    mret_i = 1'b0;
    expect_rd("mret_mstatus", ADDR_MSTATUS, 32'h0000_0088);
    check("mret_irq_o", {31'd0, irq_o}, 32'd1);
    irq_i = '0;
    cycle();
    check("irq_drop_irq_o", {31'd0, irq_o}, 32'd0);
    expect_rd("irq_drop_mip", ADDR_MIP, 32'h0);

    // trap + mret + mepc write in one cycle: trap wins everything it touches.
    trap_i             = 1'b1;
    mret_i             = 1'b1;
    pc_i               = 32'h0000_0204;
    mcause_i           = 32'h0000_0002;
    bus.opcode_i       = CSR_RW;
    bus.addr_i         = ADDR_MEPC;
    bus.rs1_data_i     = 32'hDEAD_BEE0;
    bus.write_enable_i = 1'b1;
    cycle();
    trap_i = 1'b0;
    mret_i = 1'b0;
    bus.write_enable_i = 1'b0;
    check("prio_mepc", mepc_o, 32'h0000_0204);
    expect_rd("prio_mcause", ADDR_MCAUSE, 32'h0000_0002);
    expect_rd("prio_mstatus", ADDR_MSTATUS, 32'h0000_0080);

    // trap with a write to an untouched register: both happen.
    trap_i   = 1'b1;
    pc_i     = 32'h0000_0300;
    mcause_i = 32'h0000_0007;
    bus.opcode_i       = CSR_RW;
    bus.addr_i         = ADDR_MSCRATCH;
    bus.rs1_data_i     = 32'h0000_0055;
    bus.write_enable_i = 1'b1;
    cycle();
    trap_i = 1'b0;
    bus.write_enable_i = 1'b0;
    check("trap_wr_mepc", mepc_o, 32'h0000_0300);
    expect_rd("trap_wr_mscratch", ADDR_MSCRATCH, 32'h0000_0055);
    expect_rd("trap_wr_mstatus", ADDR_MSTATUS, 32'h0000_0000);

    // mret beats an mstatus write in the same cycle.
    mret_i             = 1'b1;
    bus.opcode_i       = CSR_RW;
    bus.addr_i         = ADDR_MSTATUS;
    bus.rs1_data_i     = 32'h0;
    bus.write_enable_i = 1'b1;
    cycle();
    mret_i = 1'b0;
    bus.write_enable_i = 1'b0;
    expect_rd("mret_vs_wr_mstatus", ADDR_MSTATUS, 32'h0000_0080);

    // Alignment masks and mstatus writable bits.
    csr_op(CSR_RW, ADDR_MEPC, 32'h0000_0123, 32'h0);
    expect_rd("mepc_align", ADDR_MEPC, 32'h0000_0120);
    csr_op(CSR_RW, ADDR_MTVEC, 32'h0000_0203, 32'h0);
    expect_rd("mtvec_align", ADDR_MTVEC, 32'h0000_0200);
    check("mtvec_o", mtvec_o, 32'h0000_0200);
    csr_op(CSR_RW, ADDR_MSTATUS, 32'h0000_1234, 32'h0);
    expect_rd("mstatus_1234", ADDR_MSTATUS, 32'h0000_0000);
    csr_op(CSR_RW, ADDR_MSTATUS, 32'hFFFF_FFFF, 32'h0);
    expect_rd("mstatus_all", ADDR_MSTATUS, 32'h0000_0088);
    csr_op(CSR_RW, ADDR_MCAUSE, 32'hA5A5_0003, 32'h0);
    expect_rd("mcause_wr", ADDR_MCAUSE, 32'hA5A5_0003);

    // illegal_o: mip is read-only but legal, unmapped addresses flag.
    bus.opcode_i       = CSR_RW;
    bus.addr_i         = ADDR_MIP;
    bus.rs1_data_i     = 32'hFFFF_FFFF;
    bus.write_enable_i = 1'b1;
    #1;
    check("mip_wr_illegal", {31'd0, bus.illegal_o}, 32'd0);
    cycle();
    bus.write_enable_i = 1'b0;
    expect_rd("mip_wr_ignored", ADDR_MIP, 32'h0);
    bus.addr_i         = 12'h7C0;
    bus.write_enable_i = 1'b1;
    #1;
    check("unmapped_illegal", {31'd0, bus.illegal_o}, 32'd1);
    bus.write_enable_i = 1'b0;
    #1;
    check("unmapped_no_we", {31'd0, bus.illegal_o}, 32'd0);
    cycle();

`ifdef CSR_COUNTERS_EN
    // mcycle low-half write then carry into mcycleh.
    csr_op(CSR_RW, ADDR_MCYCLE, 32'hFFFF_FFFF, 32'h0);
    expect_rd("mcycle_wr", ADDR_MCYCLE, 32'hFFFF_FFFF);
    expect_rd("mcycleh_pre", ADDR_MCYCLEH, 32'h0);
    cycle();
    expect_rd("mcycle_wrap", ADDR_MCYCLE, 32'h0);
    expect_rd("mcycleh_carry", ADDR_MCYCLEH, 32'h1);
    cycle();
    // High-half write keeps the low half frozen for that cycle.
    csr_rd(ADDR_MCYCLE, lo_before);
    csr_op(CSR_RW, ADDR_MCYCLEH, 32'h0000_0007, 32'h0);
    expect_rd("mcycleh_wr", ADDR_MCYCLEH, 32'h0000_0007);
    expect_rd("mcycle_held", ADDR_MCYCLE, lo_before);
    // minstret: write suppresses the increment, then counts instret_i.
    instret_i = 1'b1;
    csr_op(CSR_RW, ADDR_MINSTRET, 32'h0000_0005, 32'h0);
    expect_rd("minstret_wr", ADDR_MINSTRET, 32'h0000_0005);
    cycle();
    expect_rd("minstret_inc", ADDR_MINSTRET, 32'h0000_0006);
    instret_i = 1'b0;
    cycle();
    expect_rd("minstret_hold", ADDR_MINSTRET, 32'h0000_0006);
    expect_rd("minstreth", ADDR_MINSTRETH, 32'h0);
`else
    // Counters absent: addresses read 0 and writes are illegal.
    instret_i = 1'b1;
    expect_rd("mcycle_unmapped", ADDR_MCYCLE, 32'h0);
    expect_rd("minstret_unmapped", ADDR_MINSTRET, 32'h0);
    bus.addr_i         = ADDR_MCYCLEH;
    bus.write_enable_i = 1'b1;
    #1;
    check("mcycleh_illegal", {31'd0, bus.illegal_o}, 32'd1);
    cycle();
    bus.write_enable_i = 1'b0;
    instret_i = 1'b0;
    expect_rd("mcycleh_unmapped", ADDR_MCYCLEH, 32'h0);
`endif

    // Async reset arriving mid-cycle with a trap and a write pending.
    trap_i             = 1'b1;
    pc_i               = 32'h0000_0400;
    bus.opcode_i       = CSR_RW;
    bus.addr_i         = ADDR_MSCRATCH;
    bus.rs1_data_i     = 32'h0000_AAAA;
    bus.write_enable_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst_mscratch", bus.read_data_o, 32'h0);
    check("arst_mepc_o", mepc_o, 32'h0);
    check("arst_mtvec_o", mtvec_o, MTVEC_RST);
    cycle();
    check("arst_hold_mscratch", bus.read_data_o, 32'h0);
    check("arst_hold_mepc_o", mepc_o, 32'h0);
    trap_i             = 1'b0;
    bus.write_enable_i = 1'b0;
    rst_ni             = 1'b1;
    cycle();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
